// File: rtl/reg_wb_if.sv
// -----------------------------------------------------------------------------
// reg_wb_if
// Purpose : bundles the write-back unit's request handshakes, register file
//           write port, hazard query and occupancy into one interface.
// Signals :
//   alu_valid/alu_rd/alu_data/alu_ready  ALU result write request handshake
//   mem_valid/mem_rd/mem_data/mem_ready  load result write request handshake
//   rd/reg_write_data/reg_write          register file write port
//   rs/rt, rs_pending/rt_pending         read-address hazard query
//   fifo_count                           occupied write-queue entries
// Modports: master = request/query side, slave = write-back unit.
// -----------------------------------------------------------------------------
interface reg_wb_if #(
    parameter int inst_SIZE = 16,
    parameter int DEPTH     = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 alu_valid;
    logic [2:0]           alu_rd;
    logic [inst_SIZE-1:0] alu_data;
    logic                 alu_ready;
    logic                 mem_valid;
    logic [2:0]           mem_rd;
    logic [inst_SIZE-1:0] mem_data;
    logic                 mem_ready;
    logic [2:0]           rd;
    logic [inst_SIZE-1:0] reg_write_data;
    logic                 reg_write;
    logic [2:0]           rs;
    logic [2:0]           rt;
    logic                 rs_pending;
    logic                 rt_pending;
    logic [CW-1:0]        fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs, rt,
        input  alu_ready, mem_ready, rd, reg_write_data, reg_write,
               rs_pending, rt_pending, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs, rt,
        output alu_ready, mem_ready, rd, reg_write_data, reg_write,
               rs_pending, rt_pending, fifo_count
    );
endinterface

// File: rtl/reg_writeback_unit.sv
// -----------------------------------------------------------------------------
// reg_writeback_unit
// Purpose : write side of the 8-entry register file. ALU and load results
//           arrive through valid/ready handshakes, are queued in a small FIFO
//           (load ahead of ALU when both arrive together) and retire at one
//           register write per cycle. Writes to r0 are accepted and dropped.
//           Also flags whether a register about to be read still has a write
//           in flight (queued or on the write port this cycle).
// Ports   :
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  reg_wb_if slave: request handshakes, write port, hazard query,
//        fifo_count
// -----------------------------------------------------------------------------
module reg_writeback_unit #(
    parameter int inst_SIZE = 16,
    parameter int DEPTH     = 2
) (
    input  logic     clk,
    input  logic     rst,
    reg_wb_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [2:0]           rd;
        logic [inst_SIZE-1:0] data;
    } entry_t;

    entry_t               entries_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic [2:0]           rd_q;
    logic [inst_SIZE-1:0] data_q;
    logic                 reg_write_q;

    logic [CW-1:0]        free_s;
    logic                 mem_ready_s;
    logic                 alu_ready_s;
    logic                 push_mem_s;
    logic                 push_alu_s;
    logic                 pop_s;
    logic                 rs_hit_s;
    logic                 rt_hit_s;

    // Handshake readiness from registered occupancy only; a same-cycle pop
    // never frees space, so a single free slot goes to the load path first.
    always_comb begin
        free_s      = CW'(DEPTH) - count_q;
        mem_ready_s = (free_s >= CW'(1));
        alu_ready_s = (free_s >= CW'(2)) | ((free_s == CW'(1)) & ~bus.mem_valid);
        push_mem_s  = bus.mem_valid & mem_ready_s & (bus.mem_rd != 3'd0);
        push_alu_s  = bus.alu_valid & alu_ready_s & (bus.alu_rd != 3'd0);
        pop_s       = (count_q != CW'(0));
        count_d     = count_q + CW'(push_mem_s) + CW'(push_alu_s) - CW'(pop_s);
    end

    // Queue storage, pointers and the registered register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= PW'(0);
            rd_ptr_q    <= PW'(0);
            count_q     <= CW'(0);
            rd_q        <= 3'd0;
            data_q      <= {inst_SIZE{1'b0}};
            reg_write_q <= 1'b0;
        end else begin
            // Load is the older instruction, so it takes the lower slot.
            if (push_mem_s) begin
                entries_q[wr_ptr_q] <= '{rd: bus.mem_rd, data: bus.mem_data};
            end
            if (push_alu_s) begin
                entries_q[wr_ptr_q + PW'(push_mem_s)] <= '{rd: bus.alu_rd, data: bus.alu_data};
            end
            wr_ptr_q    <= wr_ptr_q + PW'(push_mem_s) + PW'(push_alu_s);
            count_q     <= count_d;
            reg_write_q <= pop_s;
            if (pop_s) begin
                rd_q     <= entries_q[rd_ptr_q].rd;
                data_q   <= entries_q[rd_ptr_q].data;
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end else begin
                rd_q     <= rd_q;
                data_q   <= data_q;
                rd_ptr_q <= rd_ptr_q;
            end
        end
    end

    // Hazard lookup: an entry is live when its distance from the head is
    // below the occupancy; the write port itself also counts as in flight.
    always_comb begin
        rs_hit_s = reg_write_q & (rd_q == bus.rs);
        rt_hit_s = reg_write_q & (rd_q == bus.rt);
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offs;
            logic          live;
            offs     = PW'(i) - rd_ptr_q;
            live     = ({1'b0, offs} < count_q);
            rs_hit_s = rs_hit_s | (live & (entries_q[i].rd == bus.rs));
            rt_hit_s = rt_hit_s | (live & (entries_q[i].rd == bus.rt));
        end
    end

    assign bus.alu_ready      = alu_ready_s;
    assign bus.mem_ready      = mem_ready_s;
    assign bus.rd             = rd_q;
    assign bus.reg_write_data = data_q;
    assign bus.reg_write      = reg_write_q;
    assign bus.fifo_count     = count_q;
    assign bus.rs_pending     = (bus.rs != 3'd0) & rs_hit_s;
    assign bus.rt_pending     = (bus.rt != 3'd0) & rt_hit_s;
endmodule

// File: tb/tb_reg_writeback_unit.sv
module tb_reg_writeback_unit;
    localparam int W = 16;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_wb_if #(.inst_SIZE(W), .DEPTH(D)) bus();
    reg_writeback_unit #(.inst_SIZE(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [18:0] mq[$];          // {rd, data} entries awaiting retirement
    logic        m_rw = 1'b0;
    logic [2:0]  m_rd = 3'd0;
    logic [15:0] m_data = 16'd0;
    logic [15:0] rf [8];
    bit          m_alu_acc = 1'b0;
    bit          m_mem_acc = 1'b0;
    bit          started = 1'b0;

    function automatic bit m_mem_ready();
        return mq.size() < D;
    endfunction

    function automatic bit m_alu_ready();
        int f;
        f = D - mq.size();
        return (f >= 2) || (f == 1 && !bus.mem_valid);
    endfunction

    function automatic bit m_pend(input logic [2:0] r);
        if (r == 3'd0) return 1'b0;
        if (m_rw && m_rd == r) return 1'b1;
        foreach (mq[i]) if (mq[i][18:16] == r) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit ma, aa;
        started = 1'b1;
        if (m_rw) rf[m_rd] = m_data;
        if (rst) begin
            mq.delete();
            m_rw = 1'b0; m_rd = 3'd0; m_data = 16'd0;
            m_alu_acc = 1'b0; m_mem_acc = 1'b0;
        end else begin
            ma = bus.mem_valid && m_mem_ready();
            aa = bus.alu_valid && m_alu_ready();
            if (mq.size() > 0) begin
                {m_rd, m_data} = mq.pop_front();
                m_rw = 1'b1;
            end else begin
                m_rw = 1'b0;
            end
            if (ma && bus.mem_rd != 3'd0) mq.push_back({bus.mem_rd, bus.mem_data});
            if (aa && bus.alu_rd != 3'd0) mq.push_back({bus.alu_rd, bus.alu_data});
            m_mem_acc = ma;
            m_alu_acc = aa;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("reg_write",  {31'd0, bus.reg_write}, {31'd0, m_rw});
            chk("rd",         {29'd0, bus.rd}, {29'd0, m_rd});
            chk("data",       {16'd0, bus.reg_write_data}, {16'd0, m_data});
            chk("fifo_count", {30'd0, bus.fifo_count}, mq.size());
            chk("mem_ready",  {31'd0, bus.mem_ready}, {31'd0, m_mem_ready()});
            chk("alu_ready",  {31'd0, bus.alu_ready}, {31'd0, m_alu_ready()});
            chk("rs_pending", {31'd0, bus.rs_pending}, {31'd0, m_pend(bus.rs)});
            chk("rt_pending", {31'd0, bus.rt_pending}, {31'd0, m_pend(bus.rt)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = 3'd0; bus.alu_data = 16'd0;
        bus.mem_valid = 1'b0; bus.mem_rd = 3'd0; bus.mem_data = 16'd0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'd0;
        idle();
        bus.rs = 3'd0; bus.rt = 3'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: idle after reset
        chk("t1_rw", {31'd0, bus.reg_write}, 32'd0);
        chk("t1_rd", {29'd0, bus.rd}, 32'd0);
        chk("t1_data", {16'd0, bus.reg_write_data}, 32'd0);
        chk("t1_count", {30'd0, bus.fifo_count}, 32'd0);
        chk("t1_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t1_alu_ready", {31'd0, bus.alu_ready}, 32'd1);

        // 2: single ALU write, hazard on rs=3 until retired
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 16'h1234; bus.rs = 3'd3;
        #1 chk("t2_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        tick();
        idle();
        #1;
        chk("t2_rw_E", {31'd0, bus.reg_write}, 32'd0);
        chk("t2_pend_E", {31'd0, bus.rs_pending}, 32'd1);
        tick();
        chk("t2_rw", {31'd0, bus.reg_write}, 32'd1);
        chk("t2_rd", {29'd0, bus.rd}, 32'd3);
        chk("t2_data", {16'd0, bus.reg_write_data}, 32'h1234);
        chk("t2_pend", {31'd0, bus.rs_pending}, 32'd1);
        tick();
        chk("t2_rw_after", {31'd0, bus.reg_write}, 32'd0);
        chk("t2_pend_after", {31'd0, bus.rs_pending}, 32'd0);

        // 3: both sources, same register, load first
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd2; bus.mem_data = 16'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd2; bus.alu_data = 16'h5555;
        #1;
        chk("t3_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("t3_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        tick();
        idle();
        chk("t3_count2", {30'd0, bus.fifo_count}, 32'd2);
        tick();
        chk("t3_first", {16'd0, bus.reg_write_data}, 32'hAAAA);
        tick();
        chk("t3_second", {16'd0, bus.reg_write_data}, 32'h5555);
        tick();
        chk("t3_rw_off", {31'd0, bus.reg_write}, 32'd0);
        chk("t3_r2", {16'd0, rf[2]}, 32'h5555);

        // 4: eight back-to-back ALU writes
        for (int i = 0; i < 8; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 3'((i % 7) + 1); bus.alu_data = 16'h0100 + 16'(i);
            #1 chk("t4_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
            tick();
            if (i > 0) begin
                chk("t4_rw", {31'd0, bus.reg_write}, 32'd1);
                chk("t4_data", {16'd0, bus.reg_write_data}, 32'h0100 + i - 1);
            end
        end
        idle();
        tick();
        chk("t4_rw_last", {31'd0, bus.reg_write}, 32'd1);
        chk("t4_data_last", {16'd0, bus.reg_write_data}, 32'h0107);
        tick();
        chk("t4_rw_off", {31'd0, bus.reg_write}, 32'd0);

        // 5: full FIFO, then an r0 request
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd4; bus.mem_data = 16'h4444;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd5; bus.alu_data = 16'h5555;
        tick();
        idle();
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd0; bus.mem_data = 16'hDEAD;
        #1;
        chk("t5_count_full", {30'd0, bus.fifo_count}, 32'd2);
        chk("t5_mem_ready_full", {31'd0, bus.mem_ready}, 32'd0);
        chk("t5_alu_ready_full", {31'd0, bus.alu_ready}, 32'd0);
        tick();
        chk("t5_mem_ready_1", {31'd0, bus.mem_ready}, 32'd1);
        chk("t5_alu_ready_1", {31'd0, bus.alu_ready}, 32'd0);
        chk("t5_rd4", {29'd0, bus.rd}, 32'd4);
        tick();
        idle();
        chk("t5_rd5", {29'd0, bus.rd}, 32'd5);
        chk("t5_count0", {30'd0, bus.fifo_count}, 32'd0);
        tick();
        chk("t5_no_r0_write", {31'd0, bus.reg_write}, 32'd0);

        // 6: reset with two entries queued
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd6; bus.mem_data = 16'h6666;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd7; bus.alu_data = 16'h7777;
        tick();
        idle();
        bus.rs = 3'd6; bus.rt = 3'd7;
        chk("t6_count2", {30'd0, bus.fifo_count}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rw", {31'd0, bus.reg_write}, 32'd0);
        chk("t6_count", {30'd0, bus.fifo_count}, 32'd0);
        chk("t6_rs_pend", {31'd0, bus.rs_pending}, 32'd0);
        chk("t6_rt_pend", {31'd0, bus.rt_pending}, 32'd0);

        // Randomised traffic; a refused request is held unchanged.
        for (int c = 0; c < 2000; c++) begin
            if (!bus.alu_valid || m_alu_acc) begin
                bus.alu_valid = ($urandom_range(0, 99) < 60);
                bus.alu_rd    = 3'($urandom_range(0, 7));
                bus.alu_data  = 16'($urandom);
            end
            if (!bus.mem_valid || m_mem_acc) begin
                bus.mem_valid = ($urandom_range(0, 99) < 45);
                bus.mem_rd    = 3'($urandom_range(0, 7));
                bus.mem_data  = 16'($urandom);
            end
            bus.rs = 3'($urandom_range(0, 7));
            bus.rt = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
